// File: rtl/servo_pkg.sv
// Shared encodings for the servo run arbiter: direction codes, FSM states
// and the direction sanitiser.
package servo_pkg;

  localparam logic [1:0] DIR_STOP = 2'b00;
  localparam logic [1:0] DIR_POS  = 2'b01;
  localparam logic [1:0] DIR_NEG  = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    COOL = 2'd2
  } state_t;

  // The illegal code 11 is treated as an explicit stop.
  function automatic logic [1:0] sanitize_dir(input logic [1:0] dir);
    case (dir)
      DIR_POS, DIR_NEG: return dir;
      default:          return DIR_STOP;
    endcase
  endfunction

endpackage

// File: rtl/servo_tick_gen.sv
// Free-running prescaler: tick is high while the count sits at TICK_DIV-1.
// clr restarts the count from 0 on the next edge.
module servo_tick_gen #(
  parameter logic [26:0] TICK_DIV = 27'd100_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int            CW   = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 27'd1);

  logic [CW-1:0] cnt_q, cnt_d;

  // NOTE: every signal written in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clr || (cnt_q == LAST)) cnt_d = '0;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of block ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign tick = (cnt_q == LAST);

endmodule

// File: rtl/servo_run_arbiter.sv
// Two-requester arbiter for one servo channel: timed runs followed by a
// stopped dead-time. Define SERVO_FIXED_PRIO_EN for fixed priority (req 0 wins).
module servo_run_arbiter #(
  parameter logic [26:0] TICK_DIV   = 27'd100_000_000,
  parameter int          RT_W       = 4,
  parameter int          DEAD_TICKS = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      req,
  input  logic [1:0]      req_dir0,
  input  logic [1:0]      req_dir1,
  input  logic [RT_W-1:0] req_time0,
  input  logic [RT_W-1:0] req_time1,
  input  logic            abort,
  output logic [1:0]      grant,
  output logic [1:0]      done,
  output logic            busy,
  output logic            servo_en,
  output logic [1:0]      servo_dir
);

  import servo_pkg::*;

  localparam int DW = (DEAD_TICKS > 1) ? $clog2(DEAD_TICKS + 1) : 1;

  state_t          state_q, state_d;
  logic [RT_W-1:0] rem_q, rem_d;
  logic [DW-1:0]   cool_q, cool_d;
  logic [1:0]      grant_q, grant_d;
  logic [1:0]      done_q, done_d;
  logic            busy_q, busy_d;
  logic            en_q, en_d;
  logic [1:0]      sdir_q, sdir_d;

  logic            win;
  logic [1:0]      win_dir;
  logic [RT_W-1:0] win_time;
  logic            tick;
  logic            clr;

`ifdef SERVO_FIXED_PRIO_EN
  always_comb win = ~req[0];
`else
  logic last_q, last_d;

  always_comb begin
    if (req == 2'b11) win = ~last_q;
    else              win = req[1];
  end

  always_comb begin
    last_d = last_q;
    if ((state_q == IDLE) && (req != 2'b00)) last_d = win;
  end

  // NOTE: the pointer resets to 1 so requester 0 takes the first tie.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) last_q <= 1'b1;
    else      last_q <= last_d;
  end
`endif

  assign win_dir  = sanitize_dir(win ? req_dir1 : req_dir0);
  assign win_time = win ? req_time1 : req_time0;

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    cool_d  = cool_q;
    grant_d = grant_q;
    done_d  = 2'b00;
    en_d    = en_q;
    sdir_d  = sdir_q;

    case (state_q)
      IDLE: begin
        if (req != 2'b00) begin
          grant_d = win ? 2'b10 : 2'b01;
          rem_d   = win_time;
          sdir_d  = win_dir;
          if (win_time != '0) begin
            state_d = RUN;
            en_d    = 1'b1;
          end else begin
            state_d = COOL;
            done_d  = grant_d;
            en_d    = 1'b0;
            sdir_d  = DIR_STOP;
            cool_d  = DW'(DEAD_TICKS);
          end
        end
      end

      RUN: begin
        if (tick && (rem_q != '0)) rem_d = rem_q - RT_W'(1);
        // Ending on the tick that consumes the last unit gives time*TICK_DIV cycles.
        if (abort || (tick && (rem_q <= RT_W'(1)))) begin
          state_d = COOL;
          done_d  = grant_q;
          en_d    = 1'b0;
          sdir_d  = DIR_STOP;
          cool_d  = DW'(DEAD_TICKS);
        end
      end

      COOL: begin
        grant_d = 2'b00;
        if (DEAD_TICKS == 0) begin
          state_d = IDLE;
        end else if (tick) begin
          if (cool_q != '0)       cool_d  = cool_q - DW'(1);
          if (cool_q <= DW'(1))   state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // Restarting the prescaler on every state change aligns ticks to phase entry.
  assign clr = (state_d != state_q);

  servo_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .tick (tick)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      rem_q   <= '0;
      cool_q  <= '0;
      grant_q <= 2'b00;
      done_q  <= 2'b00;
      busy_q  <= 1'b0;
      en_q    <= 1'b0;
      sdir_q  <= DIR_STOP;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      cool_q  <= cool_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      en_q    <= en_d;
      sdir_q  <= sdir_d;
    end
  end

  assign grant     = grant_q;
  assign done      = done_q;
  assign busy      = busy_q;
  assign servo_en  = en_q;
  assign servo_dir = sdir_q;

endmodule

// File: tb/tb_servo_run_arbiter.sv
// Scoreboard bench for servo_run_arbiter: stimulus pushes expected run records,
// a monitor measures each run at its done pulse and compares.
module tb_servo_run_arbiter;

  localparam int RT_W = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [1:0]      req = 2'b00;
  logic [1:0]      req_dir0 = 2'b00;
  logic [1:0]      req_dir1 = 2'b00;
  logic [RT_W-1:0] req_time0 = '0;
  logic [RT_W-1:0] req_time1 = '0;
  logic            abort = 1'b0;
  logic [1:0]      grant, done, servo_dir;
  logic            busy, servo_en;

  logic [1:0]      req_z = 2'b00;
  logic [1:0]      grant_z, done_z, servo_dir_z;
  logic            busy_z, servo_en_z;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0] done;
    int         en_len;
    logic [1:0] dir;
    int         cool_len;
  } rec_t;

  rec_t sb[$];

  always #5 clk = ~clk;

  servo_run_arbiter #(.TICK_DIV(27'd4), .RT_W(RT_W), .DEAD_TICKS(1)) dut (
    .clk(clk), .rst(rst), .req(req), .req_dir0(req_dir0), .req_dir1(req_dir1),
    .req_time0(req_time0), .req_time1(req_time1), .abort(abort),
    .grant(grant), .done(done), .busy(busy), .servo_en(servo_en), .servo_dir(servo_dir)
  );

  servo_run_arbiter #(.TICK_DIV(27'd4), .RT_W(RT_W), .DEAD_TICKS(0)) dut_z (
    .clk(clk), .rst(rst), .req(req_z), .req_dir0(req_dir0), .req_dir1(req_dir1),
    .req_time0(req_time0), .req_time1(req_time1), .abort(1'b0),
    .grant(grant_z), .done(done_z), .busy(busy_z), .servo_en(servo_en_z), .servo_dir(servo_dir_z)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [1:0] d, input int en_len, input logic [1:0] dir, input int cool_len);
    rec_t r;
    r.done = d; r.en_len = en_len; r.dir = dir; r.cool_len = cool_len;
    sb.push_back(r);
  endtask

  // Monitor state
  int         en_run   = 0;
  logic [1:0] run_dir  = 2'b00;
  bit         in_cool  = 1'b0;
  int         cool_len = 0;
  logic [1:0] rec_done, rec_grant, rec_dir;
  int         rec_en;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        en_run = 0; run_dir = 2'b00; in_cool = 1'b0; cool_len = 0;
      end else begin
        if (servo_en) begin
          if (en_run == 0) run_dir = servo_dir;
          en_run++;
        end
        if (done != 2'b00) begin
          if (in_cool) check("done_extra", done, 2'b00);
          rec_done = done; rec_grant = grant; rec_en = en_run; rec_dir = run_dir;
          en_run = 0; run_dir = 2'b00; in_cool = 1'b1; cool_len = 1;
        end else if (in_cool) begin
          if (cool_len == 1) check("grant_clear", grant, 2'b00);
          if (busy) cool_len++;
          else begin
            in_cool = 1'b0;
            if (sb.size() == 0) check("sb_underflow", 1, 0);
            else begin
              rec_t e;
              e = sb.pop_front();
              check("rec_done", rec_done, e.done);
              check("rec_grant", rec_grant, e.done);
              check("rec_en_len", rec_en, e.en_len);
              check("rec_dir", rec_dir, e.dir);
              check("rec_cool_len", cool_len, e.cool_len);
            end
          end
        end
      end
    end
  end

  task automatic hold_until_done(input int n_done);
    int seen = 0;
    for (int i = 0; i < 400 && seen < n_done; i++) begin
      @(negedge clk);
      if (done != 2'b00) seen++;
    end
    if (seen < n_done) check("done_timeout", seen, n_done);
    req = 2'b00;
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(posedge clk); #2;
      ok = !busy && !in_cool && (sb.size() == 0);
    end
    if (!ok) check("idle_timeout", 0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #12;
    check("rst_grant", grant, 2'b00);
    check("rst_busy", busy, 1'b0);
    check("rst_en", servo_en, 1'b0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    check("idle_grant", grant, 2'b00);
    check("idle_done", done, 2'b00);

    // Both requesting continuously: alternating grants, 4 en + 4 cool each
    req_dir0 = 2'b01; req_dir1 = 2'b10; req_time0 = 4'd1; req_time1 = 4'd1;
    for (int i = 0; i < 4; i++) begin
`ifdef SERVO_FIXED_PRIO_EN
      push(2'b01, 4, 2'b01, 4);
`else
      if (i % 2 == 0) push(2'b01, 4, 2'b01, 4);
      else            push(2'b10, 4, 2'b10, 4);
`endif
    end
    @(negedge clk) req = 2'b11;
    @(posedge clk); #1;
    check("t2_first_grant", grant, 2'b01);
    hold_until_done(4);
    wait_idle();

    // Single 3-tick run in the positive direction
    req_dir0 = 2'b01; req_time0 = 4'd3;
    push(2'b01, 12, 2'b01, 4);
    @(negedge clk) req = 2'b01;
    @(posedge clk); #1;
    check("t1_grant", grant, 2'b01);
    check("t1_en", servo_en, 1'b1);
    check("t1_dir", servo_dir, 2'b01);
    hold_until_done(1);
    wait_idle();

    // Abort in cycle 6 of a 5-tick run from requester 1
    req_dir1 = 2'b10; req_time1 = 4'd5;
    push(2'b10, 6, 2'b10, 4);
    @(negedge clk) req = 2'b10;
    @(posedge clk); #1;
    check("t3_grant", grant, 2'b10);
    repeat (5) @(posedge clk);
    @(negedge clk) abort = 1'b1;
    @(posedge clk); #1;
    check("t3_en_drop", servo_en, 1'b0);
    check("t3_done", done, 2'b10);
    @(negedge clk) abort = 1'b0; req = 2'b00;
    wait_idle();

    // Zero runtime: immediate done, dead-time only; abort in COOL is ignored
    req_dir0 = 2'b01; req_time0 = 4'd0;
    push(2'b01, 0, 2'b00, 4);
    @(negedge clk) req = 2'b01;
    @(posedge clk); #1;
    check("t4_done", done, 2'b01);
    check("t4_en", servo_en, 1'b0);
    check("t4_busy", busy, 1'b1);
    @(negedge clk) req = 2'b00; abort = 1'b1;
    @(negedge clk) abort = 1'b0;
    wait_idle();

    // Direction 11 becomes a timed stop
    req_dir0 = 2'b11; req_time0 = 4'd2;
    push(2'b01, 8, 2'b00, 4);
    @(negedge clk) req = 2'b01;
    @(posedge clk); #1;
    check("t5_en", servo_en, 1'b1);
    check("t5_dir", servo_dir, 2'b00);
    hold_until_done(1);
    wait_idle();

    // Asynchronous reset in the middle of a run
    req_dir0 = 2'b01; req_time0 = 4'd5;
    @(negedge clk) req = 2'b01;
    @(posedge clk); #1;
    check("t6_run_en", servo_en, 1'b1);
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("t6_rst_grant", grant, 2'b00);
    check("t6_rst_en", servo_en, 1'b0);
    check("t6_rst_busy", busy, 1'b0);
    check("t6_rst_dir", servo_dir, 2'b00);
    req = 2'b11; req_dir1 = 2'b10; req_time0 = 4'd1; req_time1 = 4'd1;
    push(2'b01, 4, 2'b01, 4);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    check("t6_first_grant", grant, 2'b01);
    hold_until_done(1);
    wait_idle();

    // Zero dead-time instance: COOL is just the done cycle
    begin
      int n = 0;
      req_dir0 = 2'b01; req_time0 = 4'd1;
      @(negedge clk) req_z = 2'b01;
      for (int i = 0; i < 50 && done_z == 2'b00; i++) begin
        @(posedge clk); #1;
        if (servo_en_z) n++;
      end
      check("z_done", done_z, 2'b01);
      check("z_en_len", n, 4);
      check("z_busy_done", busy_z, 1'b1);
      @(negedge clk) req_z = 2'b00;
      @(posedge clk); #1;
      check("z_busy_clear", busy_z, 1'b0);
      check("z_grant_clear", grant_z, 2'b00);
    end

    check("sb_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/servo_run_arbiter.md
Name: servo_run_arbiter

Overview:
Shares one servo PWM channel pair between two requesters. Each requester asks for a timed run in a given direction. The block arbitrates round-robin, latches the winning command, and drives servo_en/servo_dir to the PWM generator for an exact number of prescaled ticks. After every run it enforces a stopped dead-time, so the motor never reverses directly.

Parameters:
TICK_DIV, 27'd100_000_000, clock cycles per runtime tick (minimum 2)
RT_W, 4, width of runtime request fields
DEAD_TICKS, 1, stopped ticks forced after every run (0 = no cooldown)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-low (asserted when 0)
req  in  2  per-requester run request, level; hold until own done
req_dir0  in  2  requester 0 direction: 01 pos, 10 neg, 00/11 stop
req_dir1  in  2  requester 1 direction
req_time0  in  RT_W  requester 0 runtime in ticks
req_time1  in  RT_W  requester 1 runtime in ticks
abort  in  1  terminate current run early
grant  out  2  one-hot owner of servo; 00 when free
done  out  2  one-cycle pulse to owner at run end
busy  out  1  high in RUN or COOL
servo_en  out  1  enable to PWM generator
servo_dir  out  2  direction to PWM generator (00 = stop)

Behaviour:
- Reset (rst=0, async): state IDLE; all outputs 0; prescaler 0; round-robin pointer last=1, so requester 0 wins the first tie.
- States: IDLE, RUN, COOL. All outputs are registered.
- IDLE:
  - If any req bit is set, the edge selects a winner. With a single request, that requester wins. With both requests, the requester other than `last` wins.
  - On that edge: latch the winner's dir and time, set grant one-hot, set last := winner, clear the prescaler.
  - If latched time ≠ 0: go to RUN.
  - If latched time = 0: go to COOL with done[winner]=1 and servo_en=0.
- Direction 11 is latched as 00. Run with servo_en=1, servo_dir=00 (timed stop).
- RUN:
  - servo_en=1 and servo_dir=latched dir for exactly time×TICK_DIV cycles.
  - Prescaler counts 0..TICK_DIV-1 and emits a tick at TICK_DIV-1. The tick decrements the remaining count.
  - When remaining reaches 0: go to COOL, servo_en=0, servo_dir=00, done[owner]=1 for one cycle.
- abort in RUN: on the same edge, behave as normal completion (COOL, done pulse). abort outside RUN is ignored.
- COOL:
  - Lasts DEAD_TICKS×TICK_DIV cycles, including the done cycle. The prescaler is cleared on entry.
  - grant clears the cycle after done. busy stays high.
  - When the count expires: go to IDLE, busy=0.
  - If DEAD_TICKS=0: COOL lasts exactly 1 cycle (the done cycle).
- req changes during RUN/COOL do not affect the latched command.
- A requester still holding req in IDLE is re-arbitrated normally. The round-robin pointer gives the other requester priority if it is also asking.
- done and grant are never asserted to a requester that is not the owner. At most one done bit is high at a time.
- The remaining counter is RT_W bits and never wraps; the decrement is gated at 0.

Optional Feature:
SERVO_FIXED_PRIO_EN
- Defined: arbitration is fixed priority, requester 0 always wins ties. The `last` pointer is removed.
- Undefined: round-robin as described above.
- Port list is identical in both builds.

Decomposition:
- Package servo_pkg:
  - DIR_STOP=2'b00, DIR_POS=2'b01, DIR_NEG=2'b10
  - State encoding IDLE=2'd0, RUN=2'd1, COOL=2'd2
  - Function sanitising a 2-bit dir (11→00)
- Sub-module servo_tick_gen (parameter TICK_DIV; ports clk, rst, clr, tick). It is the free-running prescaler with synchronous clear. The arbiter instantiates it once.

Test Plan:
All scenarios use TICK_DIV=4 and DEAD_TICKS=1 unless stated.
1. req=01, dir0=01, time0=3:
   - grant=01 and servo_en=1, servo_dir=01 the edge after req.
   - en stays high exactly 12 cycles.
   - done=01 one cycle, then busy low after 4 cycles in COOL.
2. req=11 held continuously, time0=time1=1:
   - Grants alternate 01,10,01,…; first grant is 01.
   - Each run is 4 cycles en, 4 cycles cool.
   - Under SERVO_FIXED_PRIO_EN, grant is always 01.
3. req=10, dir1=10, time1=5, abort pulsed at cycle 6 of RUN:
   - servo_en drops on the next edge; done=10 same cycle; COOL 4 cycles.
4. req=01, time0=0:
   - servo_en never rises; done=01 the edge after req; busy 4 cycles.
5. req=01, dir0=11, time0=2:
   - servo_en=1, servo_dir=00 for 8 cycles.
6. rst driven low mid-RUN (asynchronous, between edges):
   - All outputs 0 immediately.
   - After release with req=11, the first grant is 01.
   - Also: DEAD_TICKS=0 gives a 1-cycle COOL.
